bitblade_brick_issuer: RTL and testbench

Operand-side issuer for the bit-blade PE array. It accepts one job: 16 lanes of activation/weight operands at a selectable precision of 2, 4 or 8 bits each. It decomposes every operand into 2-bit digits (bricks) and streams one brick-plane per cycle in the packed 32-bit activation/weight format the PE consumes, with per-cycle signedness flags and shift amount. The weighted sum of all issued terms reconstructs each lane's full-precision product. It sits between the operand buffers and the PE, and its o_valid/o_first/o_last tags feed the downstream accumulator.

---
 rtl/bitblade_brick_issuer.sv | 156 +++++++++++++++
 tb/tb_bitblade_brick_issuer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bitblade_brick_issuer.sv
// Brick issuer: captures one job of LANES activation/weight operands and streams
// one 2-bit brick-plane per cycle (activation digit inner loop, weight digit outer).
module bitblade_brick_issuer #(
  parameter int unsigned LANES = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [8*LANES-1:0]   i_act_vec,
  input  logic [8*LANES-1:0]   i_wgt_vec,
  input  logic [1:0]           i_a_prec,
  input  logic [1:0]           i_w_prec,
  input  logic                 i_a_signed,
  input  logic                 i_w_signed,
  output logic [2*LANES-1:0]   o_activation,
  output logic [2*LANES-1:0]   o_weight,
  output logic                 o_A_signed,
  output logic                 o_W_signed,
  output logic [3:0]           o_shift_amount,
  output logic                 o_valid,
  output logic                 o_first,
  output logic                 o_last,
  output logic                 o_err
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [8*LANES-1:0] act_q, act_d;
  logic [8*LANES-1:0] wgt_q, wgt_d;
  logic [1:0]         a_top_q, a_top_d;  // index of the top activation digit (DA-1)
  logic [1:0]         w_top_q, w_top_d;  // index of the top weight digit (DW-1)
  logic               a_signed_q, a_signed_d;
  logic               w_signed_q, w_signed_d;
  logic [1:0]         i_q, i_d;
  logic [1:0]         j_q, j_d;
  logic               err_q, err_d;

  logic [1:0] a_top_in, w_top_in;
  logic       legal, accept, is_last, issuing;
  logic [2:0] digit_sum;

  // Highest digit index for a precision code; code 11 maps to 3 but is rejected separately.
  function automatic logic [1:0] top_digit(input logic [1:0] prec);
    case (prec)
      2'b00:   top_digit = 2'd0;
      2'b01:   top_digit = 2'd1;
      default: top_digit = 2'd3;
    endcase
  endfunction

  // Job legality, handshake and term bookkeeping.
  always_comb begin
    a_top_in = top_digit(i_a_prec);
    w_top_in = top_digit(i_w_prec);
    // Largest shift 2*(i+j) must stay within 8, i.e. top digit indices sum to at most 4.
    legal    = (i_a_prec != 2'b11) && (i_w_prec != 2'b11) &&
               (({1'b0, a_top_in} + {1'b0, w_top_in}) <= 3'd4);
    issuing  = (state_q == ST_ISSUE);
    is_last  = issuing && (i_q == a_top_q) && (j_q == w_top_q);
    // Gated by reset so o_ready reads 0 while reset is held.
    o_ready  = i_rst_n && (!issuing || is_last);
    accept   = i_valid && o_ready;
  end

  // Next-state: capture on legal accept, otherwise walk i (inner) then j (outer).
  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    wgt_d      = wgt_q;
    a_top_d    = a_top_q;
    w_top_d    = w_top_q;
    a_signed_d = a_signed_q;
    w_signed_d = w_signed_q;
    i_d        = i_q;
    j_d        = j_q;
    err_d      = 1'b0;
    if (accept) begin
      i_d = 2'd0;
      j_d = 2'd0;
      if (legal) begin
        state_d    = ST_ISSUE;
        act_d      = i_act_vec;
        wgt_d      = i_wgt_vec;
        a_top_d    = a_top_in;
        w_top_d    = w_top_in;
        a_signed_d = i_a_signed;
        w_signed_d = i_w_signed;
      end else begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end
    end else if (issuing) begin
      if (is_last) begin
        state_d = ST_IDLE;
        i_d     = 2'd0;
        j_d     = 2'd0;
      end else if (i_q == a_top_q) begin
        i_d = 2'd0;
        j_d = j_q + 2'd1;
      end else begin
        i_d = i_q + 2'd1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      act_q      <= '0;
      wgt_q      <= '0;
      a_top_q    <= 2'd0;
      w_top_q    <= 2'd0;
      a_signed_q <= 1'b0;
      w_signed_q <= 1'b0;
      i_q        <= 2'd0;
      j_q        <= 2'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      wgt_q      <= wgt_d;
      a_top_q    <= a_top_d;
      w_top_q    <= w_top_d;
      a_signed_q <= a_signed_d;
      w_signed_q <= w_signed_d;
      i_q        <= i_d;
      j_q        <= j_d;
      err_q      <= err_d;
    end
  end

  // Brick-plane outputs; everything is forced to 0 when no term is issued.
  always_comb begin
    o_activation = '0;
    o_weight     = '0;
    digit_sum    = {1'b0, i_q} + {1'b0, j_q};
    if (issuing) begin
      for (int k = 0; k < LANES; k++) begin
        o_activation[2*k +: 2] = act_q[8*k + int'({i_q, 1'b0}) +: 2];
        o_weight[2*k +: 2]     = wgt_q[8*k + int'({j_q, 1'b0}) +: 2];
      end
    end
    o_valid        = issuing;
    o_first        = issuing && (i_q == 2'd0) && (j_q == 2'd0);
    o_last         = is_last;
    o_A_signed     = issuing && a_signed_q && (i_q == a_top_q);
    o_W_signed     = issuing && w_signed_q && (j_q == w_top_q);
    o_shift_amount = issuing ? {digit_sum, 1'b0} : 4'd0;
    o_err          = err_q;
  end

endmodule

// File: tb/tb_bitblade_brick_issuer.sv
// Directed bench for bitblade_brick_issuer: hand-computed brick sequences and PE sums.
module tb_bitblade_brick_issuer;

  localparam int unsigned LANES = 16;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n;
  logic                 i_valid;
  logic                 o_ready;
  logic [8*LANES-1:0]   i_act_vec;
  logic [8*LANES-1:0]   i_wgt_vec;
  logic [1:0]           i_a_prec;
  logic [1:0]           i_w_prec;
  logic                 i_a_signed;
  logic                 i_w_signed;
  logic [2*LANES-1:0]   o_activation;
  logic [2*LANES-1:0]   o_weight;
  logic                 o_A_signed;
  logic                 o_W_signed;
  logic [3:0]           o_shift_amount;
  logic                 o_valid;
  logic                 o_first;
  logic                 o_last;
  logic                 o_err;

  int checks = 0;
  int errors = 0;
  int pe_sum = 0;

  bitblade_brick_issuer #(.LANES(LANES)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_act_vec      (i_act_vec),
    .i_wgt_vec      (i_wgt_vec),
    .i_a_prec       (i_a_prec),
    .i_w_prec       (i_w_prec),
    .i_a_signed     (i_a_signed),
    .i_w_signed     (i_w_signed),
    .o_activation   (o_activation),
    .o_weight       (o_weight),
    .o_A_signed     (o_A_signed),
    .o_W_signed     (o_W_signed),
    .o_shift_amount (o_shift_amount),
    .o_valid        (o_valid),
    .o_first        (o_first),
    .o_last         (o_last),
    .o_err          (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Value of a 2-bit digit as the PE would interpret it.
  function automatic int sval(input logic [1:0] d, input logic s);
    return (s && d[1]) ? int'(d) - 4 : int'(d);
  endfunction

  task automatic offer(input logic [1:0] ap, input logic [1:0] wp, input logic as,
                       input logic ws, input logic [7:0] a0, input logic [7:0] w0);
    i_valid    = 1'b1;
    i_a_prec   = ap;
    i_w_prec   = wp;
    i_a_signed = as;
    i_w_signed = ws;
    i_act_vec  = '0;
    i_wgt_vec  = '0;
    i_act_vec[7:0] = a0;
    i_wgt_vec[7:0] = w0;
  endtask

  // Checks one issued term; dup means lane 15 carries the same digits as lane 0.
  task automatic term(input string tag, input logic [1:0] a, input logic [1:0] w,
                      input logic [3:0] sh, input logic asg, input logic wsg,
                      input logic f, input logic l, input logic rdy, input logic dup);
    logic [31:0] ea, ew;
    ea = {30'd0, a};
    ew = {30'd0, w};
    if (dup) begin
      ea[31:30] = a;
      ew[31:30] = w;
    end
    chk({tag, ".valid"}, 64'(o_valid), 64'd1);
    chk({tag, ".act"}, 64'(o_activation), 64'(ea));
    chk({tag, ".wgt"}, 64'(o_weight), 64'(ew));
    chk({tag, ".shift"}, 64'(o_shift_amount), 64'(sh));
    chk({tag, ".asg"}, 64'(o_A_signed), 64'(asg));
    chk({tag, ".wsg"}, 64'(o_W_signed), 64'(wsg));
    chk({tag, ".first"}, 64'(o_first), 64'(f));
    chk({tag, ".last"}, 64'(o_last), 64'(l));
    chk({tag, ".ready"}, 64'(o_ready), 64'(rdy));
    pe_sum += sval(o_activation[1:0], o_A_signed) * sval(o_weight[1:0], o_W_signed)
              * (1 << o_shift_amount);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, 64'(o_valid), 64'd0);
    chk({tag, ".act"}, 64'(o_activation), 64'd0);
    chk({tag, ".wgt"}, 64'(o_weight), 64'd0);
    chk({tag, ".shift"}, 64'(o_shift_amount), 64'd0);
    chk({tag, ".flags"}, 64'({o_A_signed, o_W_signed, o_first, o_last}), 64'd0);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    offer(2'b00, 2'b00, 1'b0, 1'b0, 8'h0, 8'h0);
    i_valid = 1'b0;
    #1;
    chk_idle("rst");
    chk("rst.ready", 64'(o_ready), 64'd0);
    chk("rst.err", 64'(o_err), 64'd0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    #1;
    chk("rel.ready", 64'(o_ready), 64'd1);
    chk_idle("rel");

    // 2x2 unsigned single term
    offer(2'b00, 2'b00, 1'b0, 1'b0, 8'h3, 8'h2);
    tick();
    i_valid = 1'b0;
    term("j1", 2'd3, 2'd2, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_idle("j1.after");

    // 4x4 unsigned, A=0xB W=6
    offer(2'b01, 2'b01, 1'b0, 1'b0, 8'h0B, 8'h06);
    tick();
    i_valid = 1'b0;
    pe_sum = 0;
    term("j2.t0", 2'd3, 2'd2, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    term("j2.t1", 2'd2, 2'd2, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    term("j2.t2", 2'd3, 2'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    term("j2.t3", 2'd2, 2'd1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("j2.sum", 64'(pe_sum), 64'(66));
    tick();
    chk_idle("j2.after");

    // 4x4 signed activation, A=-5 W=6
    offer(2'b01, 2'b01, 1'b1, 1'b0, 8'h0B, 8'h06);
    tick();
    i_valid = 1'b0;
    pe_sum = 0;
    term("j3.t0", 2'd3, 2'd2, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    term("j3.t1", 2'd2, 2'd2, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    term("j3.t2", 2'd3, 2'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    term("j3.t3", 2'd2, 2'd1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("j3.sum", 64'(pe_sum), 64'(-30));
    tick();

    // 2x8 A-signed job with a 2x2 job held on i_valid behind it
    offer(2'b00, 2'b10, 1'b1, 1'b0, 8'h01, 8'hE4);
    tick();
    offer(2'b00, 2'b00, 1'b0, 1'b0, 8'h02, 8'h03);
    term("j4.t0", 2'd1, 2'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    term("j4.t1", 2'd1, 2'd1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    term("j4.t2", 2'd1, 2'd2, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    term("j4.t3", 2'd1, 2'd3, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    i_valid = 1'b0;
    term("j4.next", 2'd2, 2'd3, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_idle("j4.after");

    // Illegal 8x8
    offer(2'b10, 2'b10, 1'b0, 1'b0, 8'h55, 8'h55);
    tick();
    i_valid = 1'b0;
    chk("ill88.err", 64'(o_err), 64'd1);
    chk("ill88.ready", 64'(o_ready), 64'd1);
    chk_idle("ill88");
    tick();
    chk("ill88.err_off", 64'(o_err), 64'd0);
    chk_idle("ill88.after");

    // Illegal precision code 11
    offer(2'b11, 2'b00, 1'b0, 1'b0, 8'h01, 8'h01);
    tick();
    i_valid = 1'b0;
    chk("ill11.err", 64'(o_err), 64'd1);
    chk_idle("ill11");
    tick();

    // Illegal job accepted during a last term ends the stream
    offer(2'b00, 2'b00, 1'b0, 1'b0, 8'h1, 8'h1);
    tick();
    offer(2'b10, 2'b10, 1'b0, 1'b0, 8'h1, 8'h1);
    term("illast.t0", 2'd1, 2'd1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    i_valid = 1'b0;
    chk("illast.err", 64'(o_err), 64'd1);
    chk_idle("illast");
    tick();

    // Reset during term 2 of a 4x4 job; lane 15 also carries data
    offer(2'b01, 2'b01, 1'b0, 1'b0, 8'h0B, 8'h06);
    i_act_vec[127:120] = 8'h0B;
    i_wgt_vec[127:120] = 8'h06;
    tick();
    i_valid = 1'b0;
    term("j6.t0", 2'd3, 2'd2, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    term("j6.t1", 2'd2, 2'd2, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    i_rst_n = 1'b0;
    #1;
    chk_idle("j6.rst");
    chk("j6.rst.ready", 64'(o_ready), 64'd0);
    #2 i_rst_n = 1'b1;
    #1;
    chk("j6.rel.ready", 64'(o_ready), 64'd1);
    chk_idle("j6.rel");
    tick();
    chk_idle("j6.idle");
    offer(2'b01, 2'b01, 1'b0, 1'b0, 8'h0B, 8'h06);
    i_act_vec[127:120] = 8'h0B;
    i_wgt_vec[127:120] = 8'h06;
    tick();
    i_valid = 1'b0;
    term("j7.t0", 2'd3, 2'd2, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    term("j7.t1", 2'd2, 2'd2, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    chk_idle("j7.after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
